// File: rtl/adsr_voice_alloc.sv
// Polyphonic voice allocator and gate sequencer for a bank of adsr envelopes.
// Each event is latched, the bank is scanned one voice per cycle from index 0
// upward to collect candidates, and the chosen voice is updated in one APPLY
// cycle. Retriggered or stolen voices get a timed gate-low gap so that the
// envelope sees a fresh rising gate edge.
module adsr_voice_alloc #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 7,
   parameter int AGE_W      = 8,
   parameter int RETRIG_CYC = 1134
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ev_valid,
   output logic                            ev_ready,
   input  logic                            ev_on,
   input  logic [NOTE_W-1:0]               ev_note,
   input  logic [NUM_VOICES-1:0]           voice_idle,
   output logic [NUM_VOICES-1:0]           gate,
   output logic [NUM_VOICES*NOTE_W-1:0]    voice_note,
   output logic [$clog2(NUM_VOICES)-1:0]   alloc_voice,
   output logic                            alloc_pulse,
   output logic                            steal_pulse
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int RT_W  = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [RT_W-1:0]  RT_LOAD  = RT_W'(RETRIG_CYC);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_APPLY} fsm_t;
   typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vst_t;

   fsm_t              fsm_q, fsm_d;
   logic [IDX_W-1:0]  scan_idx_q;
   logic [AGE_W-1:0]  note_cnt_q;
   logic [IDX_W-1:0]  alloc_voice_q;

   // Latched event and candidates gathered during the scan
   logic              ev_on_q;
   logic [NOTE_W-1:0] ev_note_q;
   logic              match_found_q, free_found_q, rel_found_q, held_found_q;
   logic [IDX_W-1:0]  match_idx_q, free_idx_q, rel_idx_q, held_idx_q;
   logic [AGE_W-1:0]  rel_age_q, held_age_q;

   // Per-voice state
   vst_t              vst_q   [NUM_VOICES];
   logic [NOTE_W-1:0] vnote_q [NUM_VOICES];
   logic [AGE_W-1:0]  stamp_q [NUM_VOICES];
   logic [RT_W-1:0]   rcnt_q  [NUM_VOICES];

   // Decision made in the APPLY cycle
   logic              apply_en;
   logic              apply_gap;
   logic              apply_steal;
   logic [IDX_W-1:0]  apply_tgt;

   // Voice currently under the scan pointer
   vst_t              cur_st;
   logic [NOTE_W-1:0] cur_note;
   logic [AGE_W-1:0]  cur_age;
   logic              cur_match;

   // Look at the voice under the scan pointer; age is modular so wrap is harmless
   always_comb begin
      cur_st    = vst_q[scan_idx_q];
      cur_note  = vnote_q[scan_idx_q];
      cur_age   = note_cnt_q - stamp_q[scan_idx_q];
      cur_match = 1'b0;
      if (cur_note == ev_note_q) begin
         // note-on may retrigger a releasing voice; note-off only releases a held one
         cur_match = ev_on_q ? (cur_st != V_FREE) : (cur_st == V_HELD);
      end
   end

   // FSM next state, handshake and the APPLY-cycle voice selection
   always_comb begin
      fsm_d       = fsm_q;
      ev_ready    = 1'b0;
      apply_en    = 1'b0;
      apply_gap   = 1'b0;
      apply_steal = 1'b0;
      apply_tgt   = '0;
      case (fsm_q)
         ST_IDLE: begin
            ev_ready = 1'b1;
            if (ev_valid) fsm_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (scan_idx_q == LAST_IDX) fsm_d = ST_APPLY;
         end
         ST_APPLY: begin
            fsm_d = ST_IDLE;
            if (ev_on_q) begin
               apply_en = 1'b1;
               if (match_found_q) begin
                  apply_tgt = match_idx_q;
                  apply_gap = 1'b1;
               end else if (free_found_q) begin
                  apply_tgt = free_idx_q;
               end else if (rel_found_q) begin
                  apply_tgt = rel_idx_q;
                  apply_gap = 1'b1;
               end else begin
                  // every voice is held: the oldest one is stolen
                  apply_tgt   = held_idx_q;
                  apply_gap   = 1'b1;
                  apply_steal = 1'b1;
               end
            end else if (match_found_q) begin
               apply_en  = 1'b1;
               apply_tgt = match_idx_q;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
      alloc_pulse = apply_en;
      steal_pulse = apply_steal;
      alloc_voice = apply_en ? apply_tgt : alloc_voice_q;
   end

   // Control registers: FSM, scan pointer, note counter, last allocated voice
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q         <= ST_IDLE;
         scan_idx_q    <= '0;
         note_cnt_q    <= '0;
         alloc_voice_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         if (fsm_q == ST_IDLE) begin
            scan_idx_q <= '0;
         end else if (fsm_q == ST_SCAN) begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
         end
         if (apply_en) begin
            alloc_voice_q <= apply_tgt;
            if (ev_on_q) note_cnt_q <= note_cnt_q + AGE_W'(1);
         end
      end
   end

   // Event latch and candidate tracking; candidates are cleared on every handshake
   always_ff @(posedge clk) begin
      if (fsm_q == ST_IDLE && ev_valid) begin
         ev_on_q       <= ev_on;
         ev_note_q     <= ev_note;
         match_found_q <= 1'b0;
         free_found_q  <= 1'b0;
         rel_found_q   <= 1'b0;
         held_found_q  <= 1'b0;
      end else if (fsm_q == ST_SCAN) begin
         if (cur_match && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= scan_idx_q;
         end
         if (cur_st == V_FREE && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
         end
         // strictly older replaces, so ties stay with the lower index
         if (cur_st == V_REL && (!rel_found_q || cur_age > rel_age_q)) begin
            rel_found_q <= 1'b1;
            rel_idx_q   <= scan_idx_q;
            rel_age_q   <= cur_age;
         end
         if (cur_st == V_HELD && (!held_found_q || cur_age > held_age_q)) begin
            held_found_q <= 1'b1;
            held_idx_q   <= scan_idx_q;
            held_age_q   <= cur_age;
         end
      end
   end

   // Per-voice state: APPLY wins over release-to-free and the retrig countdown
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            vst_q[i]   <= V_FREE;
            vnote_q[i] <= '0;
            stamp_q[i] <= '0;
            rcnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (apply_en && apply_tgt == IDX_W'(i)) begin
               if (ev_on_q) begin
                  vst_q[i]   <= V_HELD;
                  vnote_q[i] <= ev_note_q;
                  stamp_q[i] <= note_cnt_q;
                  rcnt_q[i]  <= apply_gap ? RT_LOAD : '0;
               end else begin
                  vst_q[i]  <= V_REL;
                  rcnt_q[i] <= '0;
               end
            end else begin
               if (vst_q[i] == V_REL && voice_idle[i]) vst_q[i] <= V_FREE;
               if (rcnt_q[i] != '0) rcnt_q[i] <= rcnt_q[i] - RT_W'(1);
            end
         end
      end
   end

   // Gate is high for held voices whose retrigger gap has run out
   always_comb begin
      gate       = '0;
      voice_note = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         gate[i]                    = (vst_q[i] == V_HELD) && (rcnt_q[i] == '0);
         voice_note[i*NOTE_W +: NOTE_W] = vnote_q[i];
      end
   end

endmodule
